// File: rtl/xor_seri_denetleyici_pkg.sv
// Shared types and constants for the serial XOR/XNOR reduction controller.
package xor_seri_denetleyici_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_seri_denetleyici_if.sv
// Two requester channels plus the result channel of the serial XOR controller.
interface xor_seri_denetleyici_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_mode;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_mode;
  logic             res_valid;
  logic             res_ready;
  logic             res_data;
  logic             res_id;

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/xor_seri_denetleyici_hucre.sv
// Convertible one-bit XOR/XNOR cell shared by both requesters.
module xor_hucre
  import xor_seri_denetleyici_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic mode,
  output logic y
);
  always_comb begin
    if (mode == MODE_XNOR) y = ~(a ^ b);
    else                   y = a ^ b;
  end
endmodule

// File: rtl/xor_seri_denetleyici_rr_hakem_2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_hakem_2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);
  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end
endmodule

// File: rtl/xor_seri_denetleyici.sv
// Serial XOR/XNOR reduction of a WIDTH-bit word, shared by two requesters via round-robin.
module xor_seri_denetleyici
  import xor_seri_denetleyici_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  xor_seri_denetleyici_if.slave  bus,
  output logic                   busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               mode_q, mode_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic               res_valid_q, res_valid_d;
  logic               res_data_q, res_data_d;

  logic grant0, grant1, take0, take1, last_step, cell_mode, cell_y;

  rr_hakem_2 u_hakem (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Only the final bit-step uses the captured mode; earlier steps plainly accumulate.
  always_comb begin
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    if (state_q == ST_RUN && last_step) cell_mode = mode_q;
    else                                cell_mode = MODE_XOR;
  end

  xor_hucre u_hucre (
    .a    (acc_q),
    .b    (sh_q[0]),
    .mode (cell_mode),
    .y    (cell_y)
  );

  always_comb begin
    take0          = (state_q == ST_IDLE) & grant0 & ~rst;
    take1          = (state_q == ST_IDLE) & grant1 & ~rst;
    bus.req0_ready = take0;
    bus.req1_ready = take1;
    bus.res_valid  = res_valid_q;
    bus.res_data   = res_data_q;
    bus.res_id     = id_q;
    busy           = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (take0 || take1) begin
          sh_d         = take1 ? bus.req1_data : bus.req0_data;
          mode_d       = take1 ? bus.req1_mode : bus.req0_mode;
          id_d         = take1;
          last_grant_d = take1;
          acc_d        = 1'b0;
          cnt_d        = '0;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = cell_y;
        sh_d  = sh_q >> 1;
        if (last_step) begin
          res_valid_d = 1'b1;
          res_data_d  = cell_y;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end
endmodule

// File: tb/tb_xor_seri_denetleyici.sv
// Directed bench for xor_seri_denetleyici with WIDTH=8 and hand-computed results.
module tb_xor_seri_denetleyici;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  xor_seri_denetleyici_if #(.WIDTH(8)) bus ();

  xor_seri_denetleyici #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: grant check, accept, 8 RUN cycles, optional stall in DONE, take.
  task automatic do_op(input logic v0, input logic v1, input logic g,
                       input logic exp_d, input int hold, input logic keep);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.res_ready  = 1'b0;
    #1;
    chk("grant_r0", {7'd0, bus.req0_ready}, {7'd0, ~g});
    chk("grant_r1", {7'd0, bus.req1_ready}, {7'd0, g});
    step();
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    for (int i = 1; i <= 8; i++) begin
      chk("run_res_valid", {7'd0, bus.res_valid}, 8'd0);
      chk("run_busy", {7'd0, busy}, 8'd1);
      chk("run_ready", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_valid", {7'd0, bus.res_valid}, 8'd1);
      chk("done_data", {7'd0, bus.res_data}, {7'd0, exp_d});
      chk("done_id", {7'd0, bus.res_id}, {7'd0, g});
      chk("done_ready", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
      chk("done_busy", {7'd0, busy}, 8'd1);
      if (h < hold) step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("taken_valid", {7'd0, bus.res_valid}, 8'd0);
    chk("taken_busy", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'b1011_0001;
    bus.req0_mode  = 1'b0;
    bus.req1_data  = 8'hFF;
    bus.req1_mode  = 1'b1;
    bus.res_ready  = 1'b0;

    // reset held two cycles with both requesters valid
    step();
    step();
    chk("rst_r0", {7'd0, bus.req0_ready}, 8'd0);
    chk("rst_r1", {7'd0, bus.req1_ready}, 8'd0);
    chk("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
    chk("rst_res_data", {7'd0, bus.res_data}, 8'd0);
    chk("rst_res_id", {7'd0, bus.res_id}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;

    // 8'b1011_0001 has four ones -> XOR 0, owner req0
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // req1 XNOR: 8'hFF -> 1, 8'h07 -> 0
    do_op(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    bus.req1_data = 8'h07;
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // both valid continuously: alternating grants starting with req0
    bus.req0_data = 8'h03; bus.req0_mode = 1'b0;
    bus.req1_data = 8'h01; bus.req1_mode = 1'b0;
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    do_op(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    bus.req0_data = 8'h80; bus.req0_mode = 1'b0;
    bus.req1_data = 8'h00; bus.req1_mode = 1'b1;
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    do_op(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);

    // consumer stalls five cycles in DONE: 8'h7F XNOR -> 0
    bus.req0_data = 8'h7F; bus.req0_mode = 1'b1;
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0);

    // abort req0 at the 4th RUN step; last_grant must return to 1
    bus.req0_data = 8'hAA; bus.req0_mode = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    #1;
    chk("abort_grant", {7'd0, bus.req0_ready}, 8'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_res_valid", {7'd0, bus.res_valid}, 8'd0);
    bus.req0_data = 8'h01; bus.req0_mode = 1'b0;
    bus.req1_data = 8'h00; bus.req1_mode = 1'b0;
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
